// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: default geometry and chunk-width math.
package adder_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_STAGES = 4;

  // Bits handled by each pipeline stage.
  function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  // True when the width splits evenly into at least one stage.
  function automatic bit legal_split(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CW-bit ripple adder made of chained full-adder cells.
module adder_slice #(
  parameter int unsigned CW = 2
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] s,
  output logic          cout,
  output logic          c_msb_in
);

  // Ripple the carry bit by bit; also expose the carry entering the top bit.
  always_comb begin
    logic c;
    c        = cin;
    s        = '0;
    c_msb_in = cin;
    for (int i = 0; i < int'(CW); i++) begin
      if (i == int'(CW) - 1) c_msb_in = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: one CW-bit chunk per stage, carry registered
// between stages, valid/ready on both ends with full backpressure.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW   = chunk_width(WIDTH, STAGES);
  localparam int unsigned LAST = STAGES - 1;

  // Per-stage payload; a/b carry full width so later stages can pick their chunk.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             msb_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  if (!legal_split(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  stage_t             st [STAGES];
  logic [STAGES-1:0]  vld;
  logic [STAGES-1:0]  adv;

  // Advance chain: a stage moves when empty or when the stage after it moves.
  always_comb begin
    logic run;
    adv       = '0;
    run       = !vld[LAST] || out_ready;
    adv[LAST] = run;
    for (int k = int'(LAST) - 1; k >= 0; k--) begin
      run    = !vld[k] || run;
      adv[k] = run;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] sum_src;
    logic             c_src;
    logic             v_src;
    logic [CW-1:0]    s;
    logic             co;
    logic             cm;
    stage_t           q;
    stage_t           nxt;

    if (k == 0) begin : g_first
      assign a_src   = a;
      assign b_src   = b;
      assign sum_src = '0;
      assign c_src   = cin;
      assign v_src   = in_valid;
    end else begin : g_next
      assign a_src   = st[k-1].a;
      assign b_src   = st[k-1].b;
      assign sum_src = st[k-1].sum;
      assign c_src   = st[k-1].carry;
      assign v_src   = st[k-1].valid;
    end

    adder_slice #(.CW(CW)) u_slice (
      .a        (a_src[k*CW +: CW]),
      .b        (b_src[k*CW +: CW]),
      .cin      (c_src),
      .s        (s),
      .cout     (co),
      .c_msb_in (cm)
    );

    // Fold this stage's chunk result into the running sum.
    always_comb begin
      nxt        = '0;
      nxt.valid  = v_src;
      nxt.sum    = sum_src;
      nxt.carry  = co;
      nxt.msb_in = cm;
      nxt.a      = a_src;
      nxt.b      = b_src;
      nxt.sum[k*CW +: CW] = s;
    end

    // Stage register; holds while the downstream stage is blocked.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q <= '0;
      end else if (adv[k]) begin
        q <= nxt;
      end
    end

    assign st[k]  = q;
    assign vld[k] = q.valid;
  end

  assign in_ready  = adv[0];
  assign out_valid = st[LAST].valid;
  assign sum       = st[LAST].sum;
  assign cout      = st[LAST].carry;
  assign ovf       = SIGNED ? (st[LAST].carry ^ st[LAST].msb_in) : 1'b0;

  // Operand copies in the last stage have no consumer.
  logic unused_last;
  assign unused_last = ^{st[LAST].a, st[LAST].b, st[LAST].msb_in};

endmodule
